// File: rtl/gmii_frame_gen_pkg.sv
// Shared GMII/PCS constants, generator state encoding and the transmit bus payload.
package gmii_frame_gen_pkg;

  localparam logic [2:0] XMIT_CONFIGURATION = 3'b001;
  localparam logic [2:0] XMIT_IDLE          = 3'b010;
  localparam logic [2:0] XMIT_DATA          = 3'b100;

  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_XMIT,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_IPG,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
  } gmii_tx_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gmii_frame_gen.sv
// GMII transmit burst generator: N_FRAMES of preamble/SFD/counting payload/IPG, gated by PCS xmit.
module gmii_frame_gen
  import gmii_frame_gen_pkg::*;
#(
  parameter int unsigned N_FRAMES     = 4,
  parameter int unsigned PAYLOAD_LEN  = 46,
  parameter int unsigned IPG_LEN      = 12,
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter logic [7:0]  SEED         = 8'h00,
  parameter bit          ERR_EN       = 1'b0,
  parameter int unsigned ERR_FRAME    = 1,
  parameter int unsigned ERR_BYTE     = 10
) (
  input  logic                              GTX_CLK,
  input  logic                              mr_main_reset,
  input  logic                              start,
  input  logic [2:0]                        xmit,
  output logic [7:0]                        TXD,
  output logic                              TX_EN,
  output logic                              TX_ER,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(N_FRAMES+1)-1:0]     frames_sent
);

  localparam int unsigned CNT_W = $clog2(max3(PREAMBLE_LEN, PAYLOAD_LEN, IPG_LEN) + 1);
  localparam int unsigned FS_W  = $clog2(N_FRAMES + 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [FS_W-1:0]  r_fs, w_fs_nxt;
  gmii_tx_t         r_tx, w_tx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic w_last_pre, w_last_pay, w_last_ipg, w_last_frame, w_xmit_data;

  assign w_last_pre   = (32'(r_cnt) == PREAMBLE_LEN - 1);
  assign w_last_pay   = (32'(r_cnt) == PAYLOAD_LEN - 1);
  assign w_last_ipg   = (32'(r_cnt) == IPG_LEN - 1);
  assign w_last_frame = (32'(r_fs) + 32'd1 == N_FRAMES);
  assign w_xmit_data  = (xmit == XMIT_DATA);

  // Next state, then outputs decoded from the next state so they register in step with it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_fs_nxt    = r_fs;
    w_tx_nxt    = '0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_WAIT_XMIT;
          w_fs_nxt    = '0;
        end
      end
      ST_WAIT_XMIT: begin
        if (w_xmit_data) w_state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (w_last_pre) w_state_nxt = ST_SFD;
        else            w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_SFD: begin
        w_state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (w_last_pay) w_state_nxt = ST_IPG;
        else            w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_IPG: begin
        // Last IPG cycle doubles as the xmit sample point, keeping back-to-back gaps at IPG_LEN.
        if (w_last_ipg) begin
          w_fs_nxt = r_fs + FS_W'(1);
          if (w_last_frame)     w_state_nxt = ST_DONE;
          else if (w_xmit_data) w_state_nxt = ST_PREAMBLE;
          else                  w_state_nxt = ST_WAIT_XMIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_PREAMBLE: begin
        w_tx_nxt.txd = GMII_PREAMBLE;
        w_tx_nxt.en  = 1'b1;
      end
      ST_SFD: begin
        w_tx_nxt.txd = GMII_SFD;
        w_tx_nxt.en  = 1'b1;
      end
      ST_PAYLOAD: begin
        w_tx_nxt.txd = 8'(32'(SEED) + 32'(w_fs_nxt) + 32'(w_cnt_nxt));
        w_tx_nxt.en  = 1'b1;
        w_tx_nxt.er  = ERR_EN && (32'(w_fs_nxt) == ERR_FRAME) && (32'(w_cnt_nxt) == ERR_BYTE);
      end
      default: ;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_fs    <= '0;
      r_tx    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fs    <= w_fs_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign TXD         = r_tx.txd;
  assign TX_EN       = r_tx.en;
  assign TX_ER       = r_tx.er;
  assign busy        = r_busy;
  assign done        = r_done;
  assign frames_sent = r_fs;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Bench for gmii_frame_gen: three parameterisations driven in lockstep against a frame-position model.
module tb_gmii_frame_gen;
  import gmii_frame_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [2:0] xmit;
  logic [7:0] txd   [3];
  logic       en    [3];
  logic       er    [3];
  logic       busy  [3];
  logic       done  [3];
  logic [2:0] fs    [3];

  gmii_frame_gen u_dut0 (
    .GTX_CLK(clk), .mr_main_reset(rst), .start(start), .xmit(xmit),
    .TXD(txd[0]), .TX_EN(en[0]), .TX_ER(er[0]), .busy(busy[0]), .done(done[0]),
    .frames_sent(fs[0])
  );

  gmii_frame_gen #(.ERR_EN(1'b1), .ERR_FRAME(1), .ERR_BYTE(10)) u_dut1 (
    .GTX_CLK(clk), .mr_main_reset(rst), .start(start), .xmit(xmit),
    .TXD(txd[1]), .TX_EN(en[1]), .TX_ER(er[1]), .busy(busy[1]), .done(done[1]),
    .frames_sent(fs[1])
  );

  // Error byte index lies beyond the 4-byte payload, so TX_ER must never fire here.
  gmii_frame_gen #(.SEED(8'hFE), .PAYLOAD_LEN(4), .ERR_EN(1'b1), .ERR_BYTE(10)) u_dut2 (
    .GTX_CLK(clk), .mr_main_reset(rst), .start(start), .xmit(xmit),
    .TXD(txd[2]), .TX_EN(en[2]), .TX_ER(er[2]), .busy(busy[2]), .done(done[2]),
    .frames_sent(fs[2])
  );

  int c_pre   [3] = '{7, 7, 7};
  int c_pay   [3] = '{46, 46, 4};
  int c_ipg   [3] = '{12, 12, 12};
  int c_n     [3] = '{4, 4, 4};
  int c_seed  [3] = '{0, 0, 254};
  int c_erren [3] = '{0, 1, 1};
  int c_ef    [3] = '{1, 1, 1};
  int c_eb    [3] = '{10, 10, 10};

  // Model: mode 0 = idle/done, 1 = waiting for xmit, 2 = sending at position m_pos of frame+gap.
  int m_mode [3];
  int m_fs   [3];
  int m_pos  [3];
  int m_done [3];

  int n_tests = 0;
  int n_fail  = 0;
  int er_cnt  [3];
  logic [7:0] er_txd;
  logic       er_en;
  bit         seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d);
    if (rst) begin
      m_mode[d] = 0; m_fs[d] = 0; m_pos[d] = 0; m_done[d] = 0;
    end else begin
      case (m_mode[d])
        0: if (start) begin m_mode[d] = 1; m_fs[d] = 0; m_done[d] = 0; end
        1: if (xmit == XMIT_DATA) begin m_mode[d] = 2; m_pos[d] = 0; end
        default: begin
          m_pos[d]++;
          if (m_pos[d] == c_pre[d] + 1 + c_pay[d] + c_ipg[d]) begin
            m_fs[d]++;
            if (m_fs[d] == c_n[d]) begin m_mode[d] = 0; m_done[d] = 1; end
            else if (xmit == XMIT_DATA) m_pos[d] = 0;
            else m_mode[d] = 1;
          end
        end
      endcase
    end
  endtask

  task automatic check_dut(input int d);
    int e_txd, e_en, e_er, p, i;
    e_txd = 0; e_en = 0; e_er = 0;
    if (m_mode[d] == 2) begin
      p = m_pos[d];
      if (p < c_pre[d]) begin
        e_txd = 'h55; e_en = 1;
      end else if (p == c_pre[d]) begin
        e_txd = 'hD5; e_en = 1;
      end else if (p < c_pre[d] + 1 + c_pay[d]) begin
        i = p - c_pre[d] - 1;
        e_txd = (c_seed[d] + m_fs[d] + i) % 256;
        e_en = 1;
        e_er = (c_erren[d] != 0 && m_fs[d] == c_ef[d] && i == c_eb[d]) ? 1 : 0;
      end
    end
    chk($sformatf("dut%0d TXD", d),         32'(txd[d]),  32'(e_txd));
    chk($sformatf("dut%0d TX_EN", d),       32'(en[d]),   32'(e_en));
    chk($sformatf("dut%0d TX_ER", d),       32'(er[d]),   32'(e_er));
    chk($sformatf("dut%0d busy", d),        32'(busy[d]), 32'((m_mode[d] != 0) ? 1 : 0));
    chk($sformatf("dut%0d done", d),        32'(done[d]), 32'(m_done[d]));
    chk($sformatf("dut%0d frames_sent", d), 32'(fs[d]),   32'(m_fs[d]));
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_dut(d);
      if (er[d] === 1'b1) er_cnt[d]++;
    end
    if (er[1] === 1'b1) begin er_txd = txd[1]; er_en = en[1]; end
  endtask

  task automatic run_until_idle(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (m_mode[0] == 0 && m_mode[1] == 0 && m_mode[2] == 0) break;
      cycle();
    end
    chk("burst_end busy0", 32'(busy[0]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_mode[d] = 0; m_fs[d] = 0; m_pos[d] = 0; m_done[d] = 0; er_cnt[d] = 0;
    end
    er_txd = 8'h00; er_en = 1'b0;
    rst = 1'b1; start = 1'b0; xmit = XMIT_DATA;
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Full default burst with xmit held at DATA.
    start = 1'b1; cycle(); start = 1'b0;
    run_until_idle(2000);
    chk("burst done0", 32'(done[0]), 32'd1);
    chk("burst frames_sent0", 32'(fs[0]), 32'd4);
    chk("err pulses dut1", 32'(er_cnt[1]), 32'd1);
    chk("err txd dut1", 32'(er_txd), 32'h0B);
    chk("err txen dut1", 32'(er_en), 32'd1);
    chk("err pulses dut0", 32'(er_cnt[0]), 32'd0);
    chk("err pulses dut2", 32'(er_cnt[2]), 32'd0);

    // Start while xmit is IDLE: nothing on the wire until xmit becomes DATA.
    xmit = XMIT_IDLE;
    start = 1'b1; cycle(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("held txen", 32'(en[0]), 32'd0);
    end
    xmit = XMIT_DATA;
    cycle();
    chk("first preamble txd", 32'(txd[0]), 32'h55);
    chk("first preamble txen", 32'(en[0]), 32'd1);
    repeat (30) cycle();
    start = 1'b1; cycle(); start = 1'b0;
    run_until_idle(2000);

    // xmit leaves DATA mid-payload: the frame completes, the next one waits.
    start = 1'b1; cycle(); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      cycle();
      if (en[0] === 1'b1 && txd[0] === 8'h05) seen = 1'b1;
    end
    chk("saw payload byte5", 32'(seen), 32'd1);
    xmit = XMIT_CONFIGURATION;
    repeat (150) cycle();
    chk("held frames_sent0", 32'(fs[0]), 32'd1);
    chk("held busy0", 32'(busy[0]), 32'd1);
    chk("held txen0", 32'(en[0]), 32'd0);
    xmit = XMIT_DATA;
    run_until_idle(2000);

    // Reset held two cycles in the middle of a payload.
    start = 1'b1; cycle(); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      cycle();
      if (en[0] === 1'b1 && txd[0] === 8'h10) seen = 1'b1;
    end
    chk("saw payload byte16", 32'(seen), 32'd1);
    rst = 1'b1;
    cycle();
    chk("reset txen", 32'(en[0]), 32'd0);
    chk("reset txd", 32'(txd[0]), 32'd0);
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset frames_sent", 32'(fs[0]), 32'd0);
    cycle();
    rst = 1'b0;
    cycle();

    // Random xmit changes, start pulses (often while busy) and occasional resets.
    repeat (3000) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       xmit = XMIT_CONFIGURATION;
          1:       xmit = XMIT_IDLE;
          default: xmit = XMIT_DATA;
        endcase
      end
      cycle();
    end
    rst = 1'b0; start = 1'b0; xmit = XMIT_DATA;
    run_until_idle(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
